stack_sequencer: RTL
====================

# stack_sequencer

Sequences multi-byte stack transfers for the CPU: pushes or pulls 1–3 bytes through page `STACK_PAGE` using the S register as pointer. It drives the S register's increment/decrement strobes and the CPU memory bus. It sits between the instruction decoder (PHA/PHP/JSR/BRK/NMI/IRQ pushes; PLA/PLP/RTS/RTI pulls) and the S register / bus mux, advancing only on `cpu_en` cycles.

## Interface
Parameters:
- `STACK_PAGE`, 8'h01, high byte of every stack address.

Ports:
- `clk` in 1, system clock.
- `reset_n` in 1, synchronous active-low reset; one clock, sampled on posedge.
- `cpu_en` in 1, CPU clock-enable; the FSM advances and strobes assert only when high.
- `cmd_valid` in 1, command request.
- `cmd_ready` out 1, high in IDLE; a command is accepted when `cmd_valid && cmd_ready && cpu_en`.
- `cmd_pull` in 1, 0 = push, 1 = pull.
- `cmd_len` in 2, byte count 1–3; 0 is illegal.
- `push_data` in 24, push payload, captured at accept.
- `s_in` in 8, current S register value.
- `s_inc` / `s_dec` out 1 each, S register strobes.
- `mem_addr` out 16, bus address.
- `mem_wd` out 8, write data.
- `mem_we` / `mem_re` out 1 each, write/read strobes.
- `mem_rd` in 8, read data, valid combinationally in the same cycle as `mem_addr`.
- `busy` out 1, not IDLE.
- `done` out 1, one-cycle completion pulse.
- `pull_data` out 24, assembled pull result.
- `stack_wrap` out 1, sticky wrap flag; see Configuration.

## Operation
- States: IDLE, PUSH, PRE_INC, PULL, DONE.
- IDLE: `cmd_ready`=1. On accept:
  - latch `push_data`, set `cnt`=`cmd_len`-1.
  - push → PUSH. Pull → PRE_INC and clear `pull_data`.
  - `cmd_len`=0: accepted and discarded, go directly to DONE with no bus or S activity.
- PUSH, each `cpu_en` cycle:
  - `mem_addr`={STACK_PAGE,`s_in`}, `mem_we`=1, `s_dec`=1.
  - `mem_wd` = latched byte `cnt`, i.e. bits [8·cnt+7:8·cnt]. Most significant used byte goes first (JSR: PCH then PCL; BRK: PCH, PCL, P).
  - `cnt`==0 → DONE, else `cnt`-1.
- PRE_INC, one `cpu_en` cycle: `s_inc`=1, `mem_addr`={STACK_PAGE,`s_in`} with `mem_re`=1 (6502 dummy read, data ignored) → PULL, `idx`=0.
- PULL, each `cpu_en` cycle:
  - `mem_addr`={STACK_PAGE,`s_in`}, `mem_re`=1.
  - `pull_data`[8·idx+7:8·idx] ← `mem_rd`.
  - `s_inc`=1 unless this is the last byte.
  - last byte → DONE, else `idx`+1.
  - Byte 0 = first pulled (RTI: P, PCL, PCH in [7:0], [15:8], [23:16]).
- DONE: `done`=1 for one `cpu_en` cycle → IDLE. `pull_data` holds until the next pull accept.
- S arithmetic is 8-bit modulo: 00→FF on dec, FF→00 on inc. The address never leaves `STACK_PAGE`.
- All strobes and `done` are combinationally gated by `cpu_en`. With `cpu_en`=0 the state, counters and `mem_addr` hold.
- `cmd_valid` is ignored outside IDLE.

## Timing
- Reset values:
  - state IDLE, `cmd_ready`=1, `busy`=0, `done`=0.
  - `s_inc`=`s_dec`=`mem_we`=`mem_re`=0.
  - `mem_addr`={STACK_PAGE,`s_in`}, `mem_wd`=0, `pull_data`=0, `stack_wrap`=0.
- Latency in enabled cycles, counted from accept: push n bytes = n bus cycles + 1 DONE cycle. Pull n = 1 + n + 1.
- The S register updates at the same posedge as the strobe. The next enabled cycle sees the new `s_in`.
- Back-to-back: a new command can be accepted the enabled cycle after DONE.
- `reset_n` low mid-operation: return to IDLE at that edge and drop all strobes. Bytes already written and S changes already made stand; no rollback.

## Configuration
- `STACK_WRAP_CHECK_EN` defined:
  - `stack_wrap` sets when a PUSH cycle has `s_in`==8'h00, or a `s_inc` cycle has `s_in`==8'hFF.
  - It clears only on reset.
- Undefined: `stack_wrap` is tied to 0 and the comparators are absent.

## Structure
- Shared CPU package holds:
  - `stack_state_t` enum (IDLE, PUSH, PRE_INC, PULL, DONE).
  - `STACK_PAGE_DEFAULT` = 8'h01.
  - `STK_LEN_*` length constants.
- Single module. No sub-module; the byte select and byte insert are local logic.

## Test plan
- Push len 2, `push_data`=24'h00_C0_12, S=FD → writes C0 @01FD then 12 @01FC; `s_dec` twice; `done` after 2 bus cycles; S=FB.
- Pull len 3, S=FA, memory 01FB=24, 01FC=34, 01FD=80 → `pull_data`=24'h80_34_24; S=FD; `s_inc` asserted exactly 3 times.
- `cpu_en` toggling 1,0,0,1 during a push len 3 → no strobes while 0; identical bus trace to the always-enabled run; same final S.
- Push len 1 at S=00 → write @0100, S=FF; `stack_wrap`=1 with the macro, 0 without.
- `reset_n` low during the second PULL cycle → next cycle IDLE, `cmd_ready`=1, `done` never pulses, `pull_data`=0.
- `cmd_len`=0 accepted → `done` pulses on the next enabled cycle; no `mem_we`/`mem_re`/`s_inc`/`s_dec`.

Source files
------------

// File: rtl/stack_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// stack_sequencer_pkg
// Shared CPU stack-sequencing definitions:
//   stack_state_t      - sequencer FSM states
//   STACK_PAGE_DEFAULT - high byte of every stack address (6502 page 1)
//   STK_LEN_*          - transfer length encodings (0 is illegal, 1..3 bytes)
//   stk_byte_sel       - picks byte n out of a 24-bit payload
// -----------------------------------------------------------------------------
package stack_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PUSH,
    PRE_INC,
    PULL,
    DONE
  } stack_state_t;

  localparam logic [7:0] STACK_PAGE_DEFAULT = 8'h01;

  localparam logic [1:0] STK_LEN_0 = 2'd0;
  localparam logic [1:0] STK_LEN_1 = 2'd1;
  localparam logic [1:0] STK_LEN_2 = 2'd2;
  localparam logic [1:0] STK_LEN_3 = 2'd3;

  // Byte n of a 24-bit word; index 3 has no byte and yields zero.
  function automatic logic [7:0] stk_byte_sel(input logic [23:0] word,
                                              input logic [1:0]  n);
    logic [7:0] b;
    case (n)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/stack_sequencer.sv
// -----------------------------------------------------------------------------
// stack_sequencer
// Sequences 1..3 byte pushes/pulls through the stack page using the external
// S register as pointer. Advances only on cpu_en cycles.
//
// Optional feature: define STACK_WRAP_CHECK_EN to enable the sticky
// stack_wrap flag; otherwise stack_wrap is tied low.
//
// Ports:
//   clk, reset_n         clock, synchronous active-low reset
//   cpu_en               CPU clock-enable; gates state advance and strobes
//   cmd_valid/cmd_ready  command handshake (ready only in IDLE)
//   cmd_pull, cmd_len    direction (1 = pull) and byte count (0 = discard)
//   push_data            push payload, latched at accept
//   s_in, s_inc, s_dec   S register value and its update strobes
//   mem_addr, mem_wd, mem_we, mem_re, mem_rd   CPU memory bus
//   busy, done           not-IDLE flag and one-cycle completion pulse
//   pull_data            assembled pull result (byte 0 = first pulled)
//   stack_wrap           sticky S wrap-around flag
// -----------------------------------------------------------------------------
module stack_sequencer
  import stack_sequencer_pkg::*;
#(
  parameter logic [7:0] STACK_PAGE = STACK_PAGE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_en,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_pull,
  input  logic [1:0]  cmd_len,
  input  logic [23:0] push_data,
  input  logic [7:0]  s_in,
  output logic        s_inc,
  output logic        s_dec,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wd,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rd,
  output logic        busy,
  output logic        done,
  output logic [23:0] pull_data,
  output logic        stack_wrap
);

  stack_state_t state_q;
  logic [1:0]   cnt_q;        // push: byte still to write; pull: index of last byte
  logic [1:0]   idx_q;        // pull: byte currently being read
  logic [23:0]  data_q;
  logic [23:0]  pull_data_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      idx_q       <= 2'd0;
      data_q      <= 24'h0;
      pull_data_q <= 24'h0;
    end else if (cpu_en) begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            data_q <= push_data;
            cnt_q  <= cmd_len - STK_LEN_1;
            if (cmd_len == STK_LEN_0) begin
              state_q <= DONE;          // illegal length: swallow, no bus traffic
            end else if (cmd_pull) begin
              state_q     <= PRE_INC;
              pull_data_q <= 24'h0;
            end else begin
              state_q <= PUSH;
            end
          end
        end
        PUSH: begin
          if (cnt_q == 2'd0) state_q <= DONE;
          else               cnt_q   <= cnt_q - 2'd1;
        end
        PRE_INC: begin
          idx_q   <= 2'd0;
          state_q <= PULL;
        end
        PULL: begin
          pull_data_q[{idx_q, 3'b000} +: 8] <= mem_rd;
          if (idx_q == cnt_q) state_q <= DONE;
          else                idx_q   <= idx_q + 2'd1;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Bus and strobes follow the state directly so S updates on the same edge
  // as the access that used it.
  assign mem_addr  = {STACK_PAGE, s_in};
  assign mem_we    = cpu_en && (state_q == PUSH);
  assign s_dec     = cpu_en && (state_q == PUSH);
  assign mem_re    = cpu_en && ((state_q == PRE_INC) || (state_q == PULL));
  // The last pulled byte leaves S pointing at it, as the 6502 does.
  assign s_inc     = cpu_en && ((state_q == PRE_INC) ||
                                ((state_q == PULL) && (idx_q != cnt_q)));
  assign mem_wd    = (state_q == PUSH) ? stk_byte_sel(data_q, cnt_q) : 8'h00;
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = cpu_en && (state_q == DONE);
  assign pull_data = pull_data_q;

`ifdef STACK_WRAP_CHECK_EN
  logic wrap_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wrap_q <= 1'b0;
    end else if ((s_dec && (s_in == 8'h00)) || (s_inc && (s_in == 8'hFF))) begin
      wrap_q <= 1'b1;
    end
  end

  assign stack_wrap = wrap_q;
`else
  assign stack_wrap = 1'b0;
`endif

endmodule
